// File: rtl/rgb_proc_pkg.sv
// Shared types and elaboration-time helpers for the RGB section controller.
// Section sizes, counter widths and the button debounce state encoding.
package rgb_proc_pkg;

  typedef enum logic [1:0] {
    DB_IDLE   = 2'd0,
    DB_ARM    = 2'd1,
    DB_HELD   = 2'd2,
    DB_DISARM = 2'd3
  } db_state_t;

  function automatic int sec_w(input int x_res, input int x_num);
    return x_res / x_num;
  endfunction

  function automatic int sec_h(input int y_res, input int y_num);
    return y_res / y_num;
  endfunction

  // Width of a counter that must hold values 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int nsec_width(input int x_num, input int y_num);
    return cnt_width(x_num * y_num);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronises one raw button and emits a single-cycle press_o once the high level is stable.
// Press appears 3+DEBOUNCE_CYCLES cycles after the edge; no backpressure, events are never queued.
module btn_debounce
  import rgb_proc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          raw;
  db_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign raw = sync_q[1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= 2'b00;
      state_q <= DB_IDLE;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter only runs while confirming a level change; any contrary sample restarts it.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    press_o = 1'b0;
    case (state_q)
      DB_IDLE: begin
        if (raw) state_d = DB_ARM;
      end
      DB_ARM: begin
        if (!raw) begin
          state_d = DB_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_HELD;
          press_o = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DB_HELD: begin
        if (!raw) state_d = DB_DISARM;
      end
      DB_DISARM: begin
        if (raw) begin
          state_d = DB_HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = DB_IDLE;
    endcase
  end

endmodule

// File: rtl/rgb_section_ctrl.sv
// Tracks pixel position from observed stream beats, reports section edges/coords and the filter enable.
// Edge pulses are registered one cycle after the beat; the stream is only observed, never stalled.
module rgb_section_ctrl
  import rgb_proc_pkg::*;
#(
  parameter int X_RESOLUTION    = 1280,
  parameter int Y_RESOLUTION    = 720,
  parameter int X_NUM_SECTIONS  = 4,
  parameter int Y_NUM_SECTIONS  = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                                              clk_i,
  input  logic                                              rst_i,
  input  logic [1:0]                                        btn_i,
  input  logic                                              hsync_i,
  input  logic                                              vsync_i,
  input  logic                                              vde_i,
  input  logic                                              valid_i,
  input  logic                                              ready_i,
  output logic                                              x_edge_o,
  output logic                                              y_edge_o,
  output logic [$clog2(X_NUM_SECTIONS)-1:0]                 sec_x_o,
  output logic [$clog2(Y_NUM_SECTIONS)-1:0]                 sec_y_o,
  output logic                                              filt_enable_o,
  output logic [X_NUM_SECTIONS*Y_NUM_SECTIONS-1:0]          led_o,
  output logic [$clog2(X_NUM_SECTIONS*Y_NUM_SECTIONS)-1:0]  sel_o
);

  localparam int SEC_W  = sec_w(X_RESOLUTION, X_NUM_SECTIONS);
  localparam int SEC_H  = sec_h(Y_RESOLUTION, Y_NUM_SECTIONS);
  localparam int NSEC   = X_NUM_SECTIONS * Y_NUM_SECTIONS;
  localparam int SX_W   = $clog2(X_NUM_SECTIONS);
  localparam int SY_W   = $clog2(Y_NUM_SECTIONS);
  localparam int NSEC_W = nsec_width(X_NUM_SECTIONS, Y_NUM_SECTIONS);
  localparam int XC_W   = cnt_width(SEC_W);
  localparam int YC_W   = cnt_width(SEC_H);

  localparam logic [XC_W-1:0]   X_LAST   = XC_W'(SEC_W - 1);
  localparam logic [YC_W-1:0]   Y_LAST   = YC_W'(SEC_H - 1);
  localparam logic [SX_W-1:0]   SX_LAST  = SX_W'(X_NUM_SECTIONS - 1);
  localparam logic [SY_W-1:0]   SY_LAST  = SY_W'(Y_NUM_SECTIONS - 1);
  localparam logic [NSEC_W-1:0] SEL_LAST = NSEC_W'(NSEC - 1);

  if (X_RESOLUTION % X_NUM_SECTIONS != 0) begin : g_chk_x
    $error("X_NUM_SECTIONS must divide X_RESOLUTION");
  end
  if (Y_RESOLUTION % Y_NUM_SECTIONS != 0) begin : g_chk_y
    $error("Y_NUM_SECTIONS must divide Y_RESOLUTION");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_chk_db
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  logic              beat;
  logic              hs_rise;
  logic [XC_W-1:0]   x_cnt_q;
  logic [YC_W-1:0]   y_cnt_q;
  logic [SX_W-1:0]   sec_x_q, sec_x_nxt;
  logic [SY_W-1:0]   sec_y_q, sec_y_nxt;
  logic              hsync_q;
  logic              x_edge_q, y_edge_q;
  logic [NSEC-1:0]   pend_q, act_q;
  logic [NSEC_W-1:0] sel_q, sec_idx;
  logic              press0, press1;

  assign beat      = valid_i & ready_i;
  assign hs_rise   = hsync_i & ~hsync_q;
  assign sec_x_nxt = (sec_x_q == SX_LAST) ? '0 : sec_x_q + 1'b1;
  assign sec_y_nxt = (sec_y_q == SY_LAST) ? '0 : sec_y_q + 1'b1;

  // Horizontal position: hsync realigns the line, active pixels advance it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_cnt_q  <= '0;
      sec_x_q  <= '0;
      x_edge_q <= 1'b0;
    end else begin
      x_edge_q <= 1'b0;
      if (beat) begin
        if (hsync_i) begin
          x_cnt_q <= '0;
          sec_x_q <= '0;
        end else if (vde_i) begin
          if (x_cnt_q == X_LAST) begin
            x_cnt_q  <= '0;
            sec_x_q  <= sec_x_nxt;
            x_edge_q <= 1'b1;
          end else begin
            x_cnt_q <= x_cnt_q + 1'b1;
          end
        end
      end
    end
  end

  // Vertical position: lines are counted on hsync rising beats; vsync wins over a coincident rise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      y_cnt_q  <= '0;
      sec_y_q  <= '0;
      hsync_q  <= 1'b0;
      y_edge_q <= 1'b0;
    end else begin
      y_edge_q <= 1'b0;
      if (beat) begin
        hsync_q <= hsync_i;
        if (vsync_i) begin
          y_cnt_q <= '0;
          sec_y_q <= '0;
        end else if (hs_rise) begin
          if (y_cnt_q == Y_LAST) begin
            y_cnt_q  <= '0;
            sec_y_q  <= sec_y_nxt;
            y_edge_q <= 1'b1;
          end else begin
            y_cnt_q <= y_cnt_q + 1'b1;
          end
        end
      end
    end
  end

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_sel (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .btn_i  (btn_i[0]),
    .press_o(press0)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_tog (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .btn_i  (btn_i[1]),
    .press_o(press1)
  );

  // The active mask copies the pending mask as it stood before any toggle landing in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sel_q  <= '0;
      pend_q <= '0;
      act_q  <= '0;
    end else begin
      if (press1) pend_q <= pend_q ^ (NSEC'(1) << sel_q);
      if (press0) sel_q <= (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
      if (beat && vsync_i) act_q <= pend_q;
    end
  end

  assign sec_idx = NSEC_W'(sec_y_q) * NSEC_W'(X_NUM_SECTIONS) + NSEC_W'(sec_x_q);

  assign x_edge_o      = x_edge_q;
  assign y_edge_o      = y_edge_q;
  assign sec_x_o       = sec_x_q;
  assign sec_y_o       = sec_y_q;
  assign filt_enable_o = act_q[sec_idx];
  assign led_o         = pend_q;
  assign sel_o         = sel_q;

endmodule

// File: doc/rgb_section_ctrl.md
Name: rgb_section_ctrl

Overview:
Controller for the RGB processing pipeline. It tracks the screen position of each accepted pixel from the stream handshake and sync flags, and reports section edges and section coordinates. It holds a per-section filter-enable mask that the user edits with two debounced buttons. Mask edits take effect only at frame boundaries, and the controller drives the filter enable for the next pixel to enter the pipeline.

Parameters:
X_RESOLUTION, 1280, active pixels per line
Y_RESOLUTION, 720, active lines per frame
X_NUM_SECTIONS, 4, horizontal sections; must divide X_RESOLUTION (elaboration assertion)
Y_NUM_SECTIONS, 2, vertical sections; must divide Y_RESOLUTION (elaboration assertion)
DEBOUNCE_CYCLES, 1000000, cycles a button level must be stable before it is accepted (>=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; one clock, asynchronous, active-high
btn_i  in  2  raw buttons: [0] advances the cursor, [1] toggles the mask bit under the cursor
hsync_i  in  1  hsync of the input beat
vsync_i  in  1  vsync of the input beat
vde_i  in  1  video-data-enable of the input beat
valid_i  in  1  input stream valid (observed only)
ready_i  in  1  input stream ready (observed only)
x_edge_o  out  1  one-cycle pulse: the last pixel of a horizontal section was accepted
y_edge_o  out  1  one-cycle pulse: the last line of a vertical section ended
sec_x_o  out  $clog2(X_NUM_SECTIONS)  section column of the next pixel
sec_y_o  out  $clog2(Y_NUM_SECTIONS)  section row of the next pixel
filt_enable_o  out  1  active_mask[sec_y_o*X_NUM_SECTIONS+sec_x_o]
led_o  out  X_NUM_SECTIONS*Y_NUM_SECTIONS  pending mask, for the board LEDs
sel_o  out  $clog2(X_NUM_SECTIONS*Y_NUM_SECTIONS)  cursor index

Behaviour:
- Constants: SEC_W = X_RESOLUTION/X_NUM_SECTIONS; SEC_H = Y_RESOLUTION/Y_NUM_SECTIONS; NSEC = X_NUM_SECTIONS*Y_NUM_SECTIONS.
- Beat: a cycle with valid_i && ready_i. Non-beat cycles change no position state.
- Reset (asynchronous): all counters, sec_x/sec_y, cursor, both masks, hsync_q and the debounce state clear to 0. Resulting outputs: x_edge_o=0, y_edge_o=0, sec_x_o=0, sec_y_o=0, sel_o=0, led_o=0, filt_enable_o=0.
- Reset asserted mid-frame: the next frame is tracked correctly after the first vsync beat.
- X tracking, per beat:
  - hsync_i=1: x_cnt and sec_x clear to 0.
  - else if vde_i=1 and x_cnt==SEC_W-1: x_cnt clears, sec_x increments (wraps from X_NUM_SECTIONS-1 to 0), x_edge_o=1 in the next cycle.
  - else if vde_i=1: x_cnt increments.
- Y tracking, per beat:
  - hsync_q holds hsync_i of the previous beat.
  - vsync_i=1: y_cnt and sec_y clear to 0; no line increment in that beat, even if hsync rises.
  - else if hsync_i && !hsync_q and y_cnt==SEC_H-1: y_cnt clears, sec_y wraps/increments, y_edge_o=1 in the next cycle.
  - else on an hsync rising beat: y_cnt increments.
- x_edge_o and y_edge_o are registered single-cycle pulses.
- filt_enable_o is combinational from the registered state and applies to the next pixel to be accepted.
- Debounce (per button):
  - FSM states IDLE, ARM, HELD, DISARM.
  - IDLE->ARM when raw=1. ARM->HELD after DEBOUNCE_CYCLES consecutive 1s; emits a one-cycle press event. ARM->IDLE on a 0.
  - HELD->DISARM when raw=0. DISARM->IDLE after DEBOUNCE_CYCLES consecutive 0s. DISARM->HELD on a 1 (no event).
  - Raw inputs pass through a 2-flop synchronizer first.
- Button effects:
  - press0: cursor = (cursor==NSEC-1) ? 0 : cursor+1.
  - press1: pending_mask[cursor] toggles.
  - Both in the same cycle: toggle uses the old cursor, then the cursor advances.
- Mask commit: on a beat with vsync_i=1, active_mask <= pending_mask. If press1 lands in the same cycle, the toggle goes to pending only and takes effect at the next vsync.

Decomposition:
- Package rgb_proc_pkg: SEC_W/SEC_H helper functions, the NSEC width localparam, and the debounce state enum.
- Sub-module btn_debounce: synchronizer, FSM and counter; emits press_o. Instantiated twice.

Test Plan (X_RESOLUTION=20, Y_RESOLUTION=8, 4x2 sections, SEC_W=5, SEC_H=4, DEBOUNCE_CYCLES=1):
1. Reset then one frame, valid_i=ready_i=1 every cycle -> x_edge_o pulses after pixels 5, 10, 15 and 20 of each line; sec_x_o steps 0,1,2,3,0; y_edge_o pulses after lines 4 and 8.
2. Random valid_i/ready_i gaps (1-10 cycles) over the same frame -> identical edge and section sequence per beat; counters never advance on non-beat cycles.
3. btn_i[0] held 3 cycles, 10 times -> sel_o goes 1..7 then wraps to 0, 1, 2; exactly one advance per hold.
4. One-cycle glitch on btn_i[1] -> no toggle. Hold at cursor 3 -> led_o=0x08 immediately; filt_enable_o stays 0 until the vsync beat, then is 1 only while sec_x_o=3 and sec_y_o=0.
5. press1 in the same cycle as a vsync beat -> led_o updates, active mask unchanged; the mask is applied at the following vsync.
6. rst_i asserted mid-line at x_cnt=3 -> all outputs 0 immediately (asynchronous); after release and a vsync/hsync beat, tracking restarts with sec_x_o=0 and sec_y_o=0.
